// File: rtl/sensor_ctrl.sv
// sensor_ctrl: receive side of the external sensor interface.
// Requests samples while enabled, stores up to DEPTH words in order and raises
// an interrupt once the buffer is full. The CPU reads words through a
// registered port and releases the buffer with sctrl_clear.
module sensor_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sctrl_en,
    input  logic          sctrl_clear,
    input  logic [AW-1:0] sctrl_addr,
    output logic [DW-1:0] sctrl_out,
    output logic          sctrl_int,
    output logic [AW:0]   sctrl_cnt,
    input  logic          sensor_ready,
    input  logic [DW-1:0] sensor_out,
    output logic          sensor_en
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_FULL   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          int_q, int_d;
    logic          sensor_en_q, sensor_en_d;
    logic [DW-1:0] out_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          accept_c;
    logic          last_c;
    logic          wr_en_c;

    // A word is taken only when our own request was out and the buffer has room.
    assign accept_c = sensor_en_q & sensor_ready & (state_q != ST_FULL);
    assign last_c   = accept_c & (cnt_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear wins, FULL holds until cleared, last accept enters FULL.
    always_comb begin
        state_d = state_q;
        if (sctrl_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_FULL: state_d = ST_FULL;
                default: begin
                    if (last_c) begin
                        state_d = ST_FULL;
                    end else if (sctrl_en) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output/datapath next values: clear drops any coincident accept.
    always_comb begin
        cnt_d       = cnt_q;
        int_d       = int_q;
        wr_en_c     = 1'b0;
        sensor_en_d = sctrl_en & ~sctrl_clear & (state_d != ST_FULL);
        if (sctrl_clear) begin
            cnt_d = '0;
            int_d = 1'b0;
        end else if (accept_c) begin
            wr_en_c = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (state_d == ST_FULL) begin
                int_d = 1'b1;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            int_q       <= 1'b0;
            sensor_en_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            int_q       <= int_d;
            sensor_en_q <= sensor_en_d;
        end
    end

    // Sample storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[cnt_q[AW-1:0]] <= sensor_out;
        end
    end

    // Registered read port; a same-edge write to the read index returns old data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
        end else begin
            out_q <= mem_q[sctrl_addr];
        end
    end

    assign sctrl_out = out_q;
    assign sctrl_int = int_q;
    assign sctrl_cnt = cnt_q;
    assign sensor_en = sensor_en_q;

endmodule

// File: tb/tb_sensor_ctrl.sv
// Self-checking bench for sensor_ctrl: directed sequences plus a vector table.
module tb_sensor_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sctrl_en;
    logic        sctrl_clear;
    logic [5:0]  sctrl_addr;
    logic [31:0] sctrl_out;
    logic        sctrl_int;
    logic [6:0]  sctrl_cnt;
    logic        sensor_ready;
    logic [31:0] sensor_out;
    logic        sensor_en;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        en;
        logic        clr;
        logic        rdy;
        logic [31:0] data;
        logic [5:0]  addr;
        logic        x_en;
        logic        x_int;
        logic [6:0]  x_cnt;
        logic        chk_out;
        logic [31:0] x_out;
    } vec_t;

    vec_t vt[$];

    sensor_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .sctrl_en     (sctrl_en),
        .sctrl_clear  (sctrl_clear),
        .sctrl_addr   (sctrl_addr),
        .sctrl_out    (sctrl_out),
        .sctrl_int    (sctrl_int),
        .sctrl_cnt    (sctrl_cnt),
        .sensor_ready (sensor_ready),
        .sensor_out   (sensor_out),
        .sensor_en    (sensor_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and land just after the edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic clr, input logic rdy, input logic [31:0] data,
                       input logic [5:0] addr, input logic x_en, input logic x_int,
                       input logic [6:0] x_cnt, input logic chk_out, input logic [31:0] x_out);
        vec_t v;
        v.en = en; v.clr = clr; v.rdy = rdy; v.data = data; v.addr = addr;
        v.x_en = x_en; v.x_int = x_int; v.x_cnt = x_cnt; v.chk_out = chk_out; v.x_out = x_out;
        vt.push_back(v);
    endtask

    initial begin
        // Clear/drop-on-clear, then disable/resume, then same-cycle read/write, then clear.
        add(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h100);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(1, 0, 1, 32'h200 + i, 0, 1, 0, 7'(i + 1), 0, 0);
        add(1, 1, 1, 32'hBAD, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 10, 1, 0, 0, 1, 32'h10A);
        for (int i = 0; i < 5; i++) add(1, 0, 1, 32'h300 + i, 9, 1, 0, 7'(i + 1), 1, 32'h209);
        add(0, 0, 0, 0, 0, 0, 0, 5, 1, 32'h300);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 32'hE00 + i, 5, 0, 0, 5, 1, 32'h205);
        add(1, 0, 0, 0, 5, 1, 0, 5, 1, 32'h205);
        add(1, 0, 1, 32'h405, 5, 1, 0, 6, 1, 32'h205);
        add(1, 0, 0, 0, 5, 1, 0, 6, 1, 32'h405);
        add(1, 0, 0, 0, 4, 1, 0, 6, 1, 32'h304);
        add(1, 0, 0, 0, 6, 1, 0, 6, 1, 32'h206);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset with enable and ready held high.
        rstn = 1'b0; sctrl_en = 1'b1; sctrl_clear = 1'b0; sctrl_addr = '0;
        sensor_ready = 1'b1; sensor_out = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_en",  32'(sensor_en), 0);
            chk("rst_int", 32'(sctrl_int), 0);
            chk("rst_cnt", 32'(sctrl_cnt), 0);
            chk("rst_out", sctrl_out, 0);
        end
        rstn = 1'b1; sensor_ready = 1'b0;
        step();
        chk("post_rst_en",  32'(sensor_en), 1);
        chk("post_rst_cnt", 32'(sctrl_cnt), 0);

        // Slow fill: one pulse every 1024 clocks.
        for (int k = 0; k < 64; k++) begin
            repeat (1023) step();
            sensor_ready = 1'b1; sensor_out = 32'h100 + k;
            step();
            sensor_ready = 1'b0;
            chk("fill_cnt", 32'(sctrl_cnt), 32'(k + 1));
            chk("fill_en",  32'(sensor_en), (k < 63) ? 1 : 0);
            chk("fill_int", 32'(sctrl_int), (k == 63) ? 1 : 0);
        end
        for (int k = 0; k < 64; k++) begin
            sctrl_addr = 6'(k);
            step();
            chk("fill_rd", sctrl_out, 32'h100 + k);
        end

        // Ready while FULL must not write.
        sensor_ready = 1'b1; sensor_out = 32'hDEAD; sctrl_addr = 6'd63;
        step();
        sensor_ready = 1'b0;
        chk("full_cnt", 32'(sctrl_cnt), 64);
        step();
        chk("full_rd",  sctrl_out, 32'h13F);
        chk("full_int", 32'(sctrl_int), 1);
        chk("full_en",  32'(sensor_en), 0);

        // Vector table.
        for (int i = 0; i < vt.size(); i++) begin
            sctrl_en = vt[i].en; sctrl_clear = vt[i].clr; sensor_ready = vt[i].rdy;
            sensor_out = vt[i].data; sctrl_addr = vt[i].addr;
            step();
            chk($sformatf("vec%0d_en", i),  32'(sensor_en), 32'(vt[i].x_en));
            chk($sformatf("vec%0d_int", i), 32'(sctrl_int), 32'(vt[i].x_int));
            chk($sformatf("vec%0d_cnt", i), 32'(sctrl_cnt), 32'(vt[i].x_cnt));
            if (vt[i].chk_out) chk($sformatf("vec%0d_out", i), sctrl_out, vt[i].x_out);
        end
        sensor_ready = 1'b0;

        // Back-to-back ready every clock.
        for (int i = 0; i < 64; i++) begin
            sensor_ready = 1'b1; sensor_out = 32'h500 + i;
            step();
            chk("b2b_cnt", 32'(sctrl_cnt), 32'(i + 1));
            chk("b2b_en",  32'(sensor_en), (i < 63) ? 1 : 0);
            chk("b2b_int", 32'(sctrl_int), (i == 63) ? 1 : 0);
        end
        sensor_out = 32'hBEEF;
        step();
        sensor_ready = 1'b0;
        chk("b2b_over_cnt", 32'(sctrl_cnt), 64);
        for (int k = 0; k < 64; k++) begin
            sctrl_addr = 6'(k);
            step();
            chk("b2b_rd", sctrl_out, 32'h500 + k);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
